// File: rtl/mwadd_pkg.sv
// Shared definitions for the sequential multi-word adder.
// Word width, FSM state encoding and the signed-overflow helper live here.
package mwadd_pkg;

    // Width of one adder slice; the wide operand is processed in chunks of this size.
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } mwadd_state_t;

    // Two's complement overflow: both addends share a sign and the result sign differs.
    function automatic logic signed_overflow(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/multiword_adder_seq_addermania.sv
// AdderMania: 32-bit combinational adder slice with carry in/out and
// signed overflow. Purely combinational; the sequential wrapper reuses it
// once per word.
module AdderMania
    import mwadd_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout,
    output logic              overflow
);

    logic [WORD_W:0] full_sum;

    // One-bit-wider add so the carry out falls into the top bit.
    always_comb begin
        full_sum = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};
    end

    assign sum      = full_sum[WORD_W-1:0];
    assign cout     = full_sum[WORD_W];
    assign overflow = signed_overflow(a[WORD_W-1], b[WORD_W-1], sum[WORD_W-1]);

endmodule

// File: rtl/multiword_adder_seq.sv
// multiword_adder_seq: WORDS x 32-bit signed adder built from a single
// 32-bit AdderMania slice, stepping one word per cycle LSW first and
// chaining the carry through a register.
//
// Optional feature: define MWADD_SUB_EN to add a 'sub' input. With sub=1
// the block computes A-B (B inverted, word-0 carry forced to 1, cin ignored).
module multiword_adder_seq
    import mwadd_pkg::*;
#(
    parameter int WORDS = 2
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WORDS*WORD_W-1:0] a,
    input  logic [WORDS*WORD_W-1:0] b,
    input  logic                    cin,
`ifdef MWADD_SUB_EN
    input  logic                    sub,
`endif
    output logic                    ready,
    output logic                    done,
    output logic [WORDS*WORD_W-1:0] sum,
    output logic                    cout,
    output logic                    overflow
);

    localparam int TOT_W = WORDS * WORD_W;
    // Wide enough to hold WORDS so the counter never wraps inside an operation.
    localparam int IDX_W = $clog2(WORDS + 1);
    // Word lookup table is padded to a power of two so idx_q indexes it fully.
    localparam int SLOTS = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    // Architectural state
    mwadd_state_t     state_q;
    logic [IDX_W-1:0] idx_q;
    logic [TOT_W-1:0] a_q;
    logic [TOT_W-1:0] b_q;       // already holds the effective B (inverted for subtract)
    logic [TOT_W-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             done_q;
    logic             ready_q;

    // Combinational helpers
    logic [WORD_W-1:0] a_slot [SLOTS];
    logic [WORD_W-1:0] b_slot [SLOTS];
    logic [WORD_W-1:0] add_a_d;
    logic [WORD_W-1:0] add_b_d;
    logic [WORD_W-1:0] add_sum_d;
    logic              add_cout_d;
    logic              add_ovf_unused;
    logic [TOT_W-1:0]  b_eff_d;
    logic              carry_in_d;
    logic [TOT_W-1:0]  sum_d;
    logic              last_word_d;
    logic              ovf_d;

    // Split the latched operands into word slots; unused slots read as zero.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < WORDS) begin : g_live
                assign a_slot[gi] = a_q[gi*WORD_W +: WORD_W];
                assign b_slot[gi] = b_q[gi*WORD_W +: WORD_W];
            end else begin : g_pad
                assign a_slot[gi] = '0;
                assign b_slot[gi] = '0;
            end
        end
    endgenerate

    assign add_a_d = a_slot[idx_q];
    assign add_b_d = b_slot[idx_q];

    // Effective B and word-0 carry as captured on an accepted start.
`ifdef MWADD_SUB_EN
    assign b_eff_d    = sub ? ~b : b;
    assign carry_in_d = sub ? 1'b1 : cin;
`else
    assign b_eff_d    = b;
    assign carry_in_d = cin;
`endif

    // The slice's own overflow only reflects a 32-bit add; the wide flag is
    // derived below from the full-width MSBs instead.
    AdderMania u_adder (
        .a        (add_a_d),
        .b        (add_b_d),
        .cin      (carry_q),
        .sum      (add_sum_d),
        .cout     (add_cout_d),
        .overflow (add_ovf_unused)
    );

    // Merge the freshly computed word into the result at position idx_q.
    always_comb begin
        sum_d = sum_q;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sum_d[i*WORD_W +: WORD_W] = add_sum_d;
            end
        end
    end

    // The top word is being produced when idx_q reaches WORDS-1, so the
    // slice output already carries the final result MSB on that cycle.
    assign last_word_d = (idx_q == LAST_IDX);
    assign ovf_d       = signed_overflow(a_q[TOT_W-1], b_q[TOT_W-1], add_sum_d[WORD_W-1]);

    // Control FSM plus datapath registers; reset wins over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        // Accept: latch operands and clear the previous result.
                        state_q <= ADD;
                        idx_q   <= '0;
                        a_q     <= a;
                        b_q     <= b_eff_d;
                        carry_q <= carry_in_d;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        ready_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ADD: begin
                    // start is deliberately ignored here.
                    sum_q   <= sum_d;
                    carry_q <= add_cout_d;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (last_word_d) begin
                        state_q <= DONE;
                        cout_q  <= add_cout_d;
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Scoreboard bench for multiword_adder_seq with WORDS=2. The driver pushes
// expected results computed with plain wide arithmetic; a monitor pops and
// compares on every done pulse.
module tb_multiword_adder_seq;

    localparam int WORDS = 2;
    localparam int W     = WORDS * 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef MWADD_SUB_EN
    logic         sub;
`endif
    logic         ready;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    multiword_adder_seq #(.WORDS(WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef MWADD_SUB_EN
        .sub      (sub),
`endif
        .ready    (ready),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   txn    = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: wide two's complement arithmetic; overflow when the exact
    // result does not fit in W signed bits.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        exp_t         r;
        logic [W:0]   u;
        logic [W+1:0] sv;
        if (s) begin
            u      = {1'b0, x} - {1'b0, y};
            r.cout = (x >= y);
            sv     = {{2{x[W-1]}}, x} - {{2{y[W-1]}}, y};
        end else begin
            u      = {1'b0, x} + {1'b0, y} + (W+1)'(c);
            r.cout = u[W];
            sv     = {{2{x[W-1]}}, x} + {{2{y[W-1]}}, y} + (W+2)'(c);
        end
        r.sum = u[W-1:0];
        r.ovf = !((sv[W+1:W-1] == 3'b000) || (sv[W+1:W-1] == 3'b111));
        r.acc = 0;
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                txn++;
                $display("txn %0d: sum=%h cout=%b ovf=%b latency=%0d", txn, sum, cout, overflow, cyc - e.acc);
                chk("sum", sum, e.sum);
                chk("cout", W'(cout), W'(e.cout));
                chk("overflow", W'(overflow), W'(e.ovf));
                chk("latency", W'(cyc - e.acc), W'(WORDS));
            end
        end
    end

    // Wait for ready, present one operation, and optionally log its expected result.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input logic ts, input bit push);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=%b expected 1 within 20 cycles", ready);
            return;
        end
        a     = ta;
        b     = tb_v;
        cin   = tc;
`ifdef MWADD_SUB_EN
        sub   = ts;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            e     = model(ta, tb_v, tc, ts);
            e.acc = cyc;
            sb.push_back(e);
        end
        start = 1'b0;
        // Scramble inputs after acceptance; the DUT must not react.
        a     = {$urandom, $urandom};
        b     = {$urandom, $urandom};
        cin   = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d results outstanding expected 0", sb.size());
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
`ifdef MWADD_SUB_EN
        sub   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_ready", W'(ready), W'(1));
        chk("reset_done", W'(done), W'(0));
        chk("reset_sum", sum, '0);
        chk("reset_cout", W'(cout), W'(0));
        chk("reset_overflow", W'(overflow), W'(0));
        rst = 1'b0;

        // Directed corners, issued back-to-back (later starts land in DONE).
        issue(64'h00000000_FFFFFFFF, 64'd1, 1'b0, 1'b0, 1'b1);
        issue(64'h7FFFFFFF_FFFFFFFF, 64'd1, 1'b0, 1'b0, 1'b1);
        issue(64'hFFFFFFFF_FFFFFFFF, 64'd1, 1'b0, 1'b0, 1'b1);
        issue(64'h80000000_00000000, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0, 1'b1);
        issue(64'd0, 64'd0, 1'b1, 1'b0, 1'b1);
        issue(64'd5, 64'hFFFFFFFF_FFFFFFF9, 1'b0, 1'b0, 1'b1);
        drain();

        // start during ADD must be ignored.
        issue(64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("busy_ready", W'(ready), W'(0));
        a     = 64'hFFFFFFFF_FFFFFFFF;
        b     = 64'hFFFFFFFF_FFFFFFFF;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();

        // Reset while the second word is pending: no done, outputs cleared.
        issue(64'h00000001_FFFFFFFF, 64'h00000002_00000001, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready", W'(ready), W'(1));
        chk("abort_done", W'(done), W'(0));
        chk("abort_sum", sum, '0);
        chk("abort_cout", W'(cout), W'(0));
        chk("abort_overflow", W'(overflow), W'(0));
        rst = 1'b0;
        repeat (5) @(negedge clk);

`ifdef MWADD_SUB_EN
        issue(64'd5, 64'd7, 1'b0, 1'b1, 1'b1);
        issue(64'h80000000_00000000, 64'd1, 1'b1, 1'b1, 1'b1);
        drain();
`endif

        // Randomized traffic with occasional idle gaps.
        for (int i = 0; i < 30; i++) begin
            logic s;
`ifdef MWADD_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            issue({pick_word(), pick_word()}, {pick_word(), pick_word()}, 1'($urandom), s, 1'b1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
